// File: rtl/driver_cfg_pkg.sv
// rtl/driver_cfg_pkg.sv - shared types and constants for the driver configuration arbiter
package driver_cfg_pkg;

  localparam int CFG_WIDTH    = 48;
  localparam int DEFAULT_NREQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_END = 2'd2,
    ST_DONE     = 2'd3
  } cfg_state_t;

endpackage

// File: rtl/cfg_rr_arbiter.sv
// rtl/cfg_rr_arbiter.sv - round-robin pick of the next requester after last_grant
module cfg_rr_arbiter
  import driver_cfg_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_last_grant,
  output logic                    o_grant_valid,
  output logic [$clog2(NREQ)-1:0] o_grant
);

  localparam int IDXW = $clog2(NREQ);

  // Scan from the farthest index back to the nearest so the lowest index strictly
  // after last_grant (modulo NREQ) is the one left standing.
  always_comb begin
    int w_idx;
    o_grant_valid = 1'b0;
    o_grant       = '0;
    w_idx         = 0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = (int'(i_last_grant) + k) % NREQ;
      if (i_req[w_idx]) begin
        o_grant_valid = 1'b1;
        o_grant       = IDXW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/driver_config_arbiter.sv
// rtl/driver_config_arbiter.sv - arbitrates requesters onto one driver config channel (optional timeout: DRIVER_CFG_TIMEOUT_EN)
module driver_config_arbiter
  import driver_cfg_pkg::*;
#(
  parameter int NREQ           = DEFAULT_NREQ,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic [NREQ-1:0]                req,
  input  logic [NREQ-1:0][CFG_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]                ack,
  output logic [NREQ-1:0]                err,
  output logic                           start_config,
  output logic [CFG_WIDTH-1:0]           config_data,
  input  logic                           end_config,
  output logic                           busy
);

  localparam int IDXW = $clog2(NREQ);

  cfg_state_t           r_state;
  cfg_state_t           w_next_state;
  logic [IDXW-1:0]      r_owner;
  logic [IDXW-1:0]      r_last_grant;
  logic [IDXW-1:0]      w_grant;
  logic                 w_grant_valid;
  logic [NREQ-1:0]      w_owner_onehot;
  logic [NREQ-1:0]      r_ack;
  logic                 r_start_config;
  logic [CFG_WIDTH-1:0] r_config_data;
  logic                 w_expire;

  cfg_rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .i_req         (req),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant       (w_grant)
  );

  assign w_owner_onehot = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;

`ifdef DRIVER_CFG_TIMEOUT_EN
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0]     r_timer;
  logic            r_timed_out;
  logic [NREQ-1:0] r_err;

  assign w_expire = (r_timer == TIMER_LAST);

  // Wait-for-end timer: cleared on issue, counts while end_config is absent.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_timer <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_timer <= '0;
    end else if (r_state == ST_WAIT_END && !end_config && !w_expire) begin
      r_timer <= r_timer + 16'd1;
    end
  end

  // Remember whether the transaction ended by expiry; end_config on the same edge wins.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_timed_out <= 1'b0;
    end else if (r_state == ST_ISSUE) begin
      r_timed_out <= 1'b0;
    end else if (r_state == ST_WAIT_END && !end_config && w_expire) begin
      r_timed_out <= 1'b1;
    end
  end

  // Error pulse rides alongside ack for the owner only.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_err <= '0;
    end else begin
      r_err <= (r_state == ST_DONE && r_timed_out) ? w_owner_onehot : '0;
    end
  end

  assign err = r_err;
`else
  assign w_expire = 1'b0;
  assign err      = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:     if (w_grant_valid) w_next_state = ST_ISSUE;
      ST_ISSUE:    w_next_state = ST_WAIT_END;
      ST_WAIT_END: if (end_config || w_expire) w_next_state = ST_DONE;
      ST_DONE:     w_next_state = ST_IDLE;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  // Latch the granted word and owner; both hold until the next grant.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_config_data <= '0;
      r_owner       <= '0;
    end else if (r_state == ST_IDLE && w_grant_valid) begin
      r_config_data <= req_data[w_grant];
      r_owner       <= w_grant;
    end
  end

  // Fairness pointer moves only when a transaction completes.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_last_grant <= IDXW'(NREQ - 1);
    end else if (r_state == ST_DONE) begin
      r_last_grant <= r_owner;
    end
  end

  // Registered one-cycle pulses for start_config and ack.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_start_config <= 1'b0;
      r_ack          <= '0;
    end else begin
      r_start_config <= (r_state == ST_ISSUE);
      r_ack          <= (r_state == ST_DONE) ? w_owner_onehot : '0;
    end
  end

  assign start_config = r_start_config;
  assign ack          = r_ack;
  assign config_data  = r_config_data;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_driver_config_arbiter.sv
// tb/tb_driver_config_arbiter.sv - self-checking bench for driver_config_arbiter
module tb_driver_config_arbiter;
  import driver_cfg_pkg::*;

  localparam int NREQ = 2;
  localparam int TO   = 100;

  logic                           clk = 1'b0;
  logic                           nrst = 1'b0;
  logic [NREQ-1:0]                req = '0;
  logic [NREQ-1:0][CFG_WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]                ack;
  logic [NREQ-1:0]                err;
  logic                           start_config;
  logic [CFG_WIDTH-1:0]           config_data;
  logic                           end_config = 1'b0;
  logic                           busy;

  always #5 clk = ~clk;

  driver_config_arbiter #(
    .NREQ           (NREQ),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .err          (err),
    .start_config (start_config),
    .config_data  (config_data),
    .end_config   (end_config),
    .busy         (busy)
  );

  typedef struct {
    int          owner;
    logic        err;
    logic [47:0] data;
  } exp_t;

  typedef struct {
    logic [1:0]  req;
    logic [47:0] d0;
    logic [47:0] d1;
    int          delay;
    int          drop;
    bit          rel;
    int          exp_owner;
    logic        exp_err;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  int   start_cnt = 0;
  exp_t exp_q[$];
  exp_t m_e;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
    end
  endtask

  always @(negedge clk) begin
    if (start_config) start_cnt++;
    if (ack !== 2'b00 || err !== 2'b00) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack_or_err", {ack, err}, 64'd0);
      end else begin
        m_e = exp_q.pop_front();
        check("ack_vector", ack, 64'd1 << m_e.owner);
        check("err_vector", err, m_e.err ? (64'd1 << m_e.owner) : 64'd0);
        check("config_data_at_ack", config_data, m_e.data);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    exp_t x;
    bit   seen;
    int   lat;
    int   k;
    req_data[0] = v.d0;
    req_data[1] = v.d1;
    req         = v.req;
    x.owner = v.exp_owner;
    x.err   = v.exp_err;
    x.data  = (v.exp_owner == 1) ? v.d1 : v.d0;
    exp_q.push_back(x);
    start_cnt = 0;
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(negedge clk);
      if (v.drop == c) req = '0;
      if (start_config) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    check("start_seen", seen, 1);
    if (!seen) return;
    check("start_latency", lat, 2);
    check("config_data_at_start", config_data, x.data);
    check("busy_in_txn", busy, 1);
    if (v.delay >= 0) begin
      repeat (v.delay) @(negedge clk);
      end_config = 1'b1;
      @(negedge clk);
      end_config = 1'b0;
      @(negedge clk);
      check("ack_two_after_end", ack[v.exp_owner], 1);
    end else begin
      k = 0;
      while (ack === 2'b00 && k < 300) begin
        @(negedge clk);
        k++;
      end
      check("timeout_ack_latency", k, TO + 1);
    end
    check("busy_low_at_ack", busy, 0);
    check("single_start", start_cnt, 1);
    if (v.rel) req = '0;
  endtask

  initial begin
    // Contention: alternating grants with per-transaction data.
    vecs.push_back('{2'b11, 48'hA5A5_0000_0001, 48'h5A5A_0000_0002, 3, 0, 1'b0, 0, 1'b0});
    vecs.push_back('{2'b11, 48'hA5A5_0000_0003, 48'h5A5A_0000_0004, 5, 0, 1'b0, 1, 1'b0});
    vecs.push_back('{2'b11, 48'hA5A5_0000_0005, 48'h5A5A_0000_0006, 2, 0, 1'b0, 0, 1'b0});
    vecs.push_back('{2'b11, 48'hA5A5_0000_0007, 48'h5A5A_0000_0008, 4, 0, 1'b1, 1, 1'b0});
    // Single request, end_config 70 cycles after start.
    vecs.push_back('{2'b01, 48'h0000_8000_1234, 48'h0, 70, 0, 1'b1, 0, 1'b0});
    // Withdrawn request: req[1] high for 2 cycles only.
    vecs.push_back('{2'b10, 48'h0, 48'hCAFE_BEEF_0042, 6, 2, 1'b1, 1, 1'b0});
`ifdef DRIVER_CFG_TIMEOUT_EN
    vecs.push_back('{2'b01, 48'h1111_2222_3333, 48'h0, -1, 0, 1'b1, 0, 1'b1});
    vecs.push_back('{2'b01, 48'h4444_5555_6666, 48'h0, TO - 1, 0, 1'b1, 0, 1'b0});
    vecs.push_back('{2'b10, 48'h0, 48'h7777_8888_9999, TO - 2, 0, 1'b1, 1, 1'b0});
    vecs.push_back('{2'b01, 48'hABCD_EF01_2345, 48'h0, 5, 0, 1'b1, 0, 1'b0});
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_start", start_config, 0);
    check("rst_busy", busy, 0);
    check("rst_config_data", config_data, 0);
    nrst = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);

    // Stray end_config while idle.
    end_config = 1'b1;
    @(negedge clk);
    end_config = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_end_busy", busy, 0);
      check("stray_end_ack", ack, 0);
    end

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of WAIT_END abandons the transaction.
    @(negedge clk);
    req_data[0] = 48'hDEAD_0000_BEEF;
    req = 2'b01;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        if (start_config) seen = 1'b1;
      end
      check("midrst_start_seen", seen, 1);
    end
    repeat (5) @(negedge clk);
    check("midrst_busy_before", busy, 1);
    nrst = 1'b0;
    #1;
    check("midrst_ack", ack, 0);
    check("midrst_err", err, 0);
    check("midrst_start", start_config, 0);
    check("midrst_busy", busy, 0);
    check("midrst_config_data", config_data, 0);
    req = '0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    end_config = 1'b1;
    @(negedge clk);
    end_config = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midrst_no_ack", ack, 0);
    end
    check("midrst_busy_after", busy, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
